// File: rtl/cache_pkg.sv
// Shared types and sizing for the direct-mapped write-back cache controller.
// Widths come from the project-wide macros so every file agrees on them.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef CACHE_LINES
`define CACHE_LINES 4
`endif

package cache_pkg;
    localparam int ADDR_W = `ADDRESS_WIDTH;
    localparam int DATA_W = `DATA_WIDTH;
    localparam int LINES  = `CACHE_LINES;

    function automatic int calc_idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int lines);
        return addr_w - $clog2(lines);
    endfunction

    localparam int IDX_W = calc_idx_w(LINES);
    localparam int TAG_W = calc_tag_w(ADDR_W, LINES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WB_REQ,
        ST_FILL_REQ,
        ST_FILL_WAIT,
        ST_RESPOND
    } cache_ctrl_state_t;

    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cache_line_t;
endpackage

// File: rtl/cache_ctrl_if.sv
// CPU-side and memory-side handshake bundle for the cache controller.
// The controller is the slave of the CPU and the initiator towards memory.
interface cache_ctrl_if;
    import cache_pkg::*;

    logic              cpu_req_valid;
    logic              cpu_req_ready;
    logic              cpu_req_we;
    logic [ADDR_W-1:0] cpu_req_addr;
    logic [DATA_W-1:0] cpu_req_wdata;
    logic              cpu_resp_valid;
    logic [DATA_W-1:0] cpu_resp_rdata;
    logic              cpu_resp_hit;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;

    modport slave (
        input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_hit,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );

    modport master (
        output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_hit,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );
endinterface

// File: rtl/cache_line_store.sv
// Line array: valid/dirty flags (reset) plus tag/data storage (not reset).
// Single synchronous write port, combinational read by index.
module cache_line_store
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output cache_line_t      rd_line,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  cache_line_t      wr_line
);
    logic [LINES-1:0]  valid_vec;
    logic [LINES-1:0]  dirty_vec;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_flags
            logic valid_reg;
            logic dirty_reg;

            // Reset wins over a same-cycle write so an abandoned fill never lands as valid.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    dirty_reg <= 1'b0;
                end else if (wr_en && wr_idx == IDX_W'(gi)) begin
                    valid_reg <= wr_line.valid;
                    dirty_reg <= wr_line.dirty;
                end
            end

            assign valid_vec[gi] = valid_reg;
            assign dirty_vec[gi] = dirty_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_line.tag;
            data_mem[wr_idx] <= wr_line.data;
        end
    end

    assign rd_line = {valid_vec[rd_idx], dirty_vec[rd_idx], tag_mem[rd_idx], data_mem[rd_idx]};
endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back, write-allocate cache sequencer: one CPU request
// at a time, dirty-victim writeback, then fill from next-level memory.
module cache_ctrl
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    cache_ctrl_if.slave bus
);
    cache_ctrl_state_t state_reg, state_next;

    logic              req_we_reg;
    logic [ADDR_W-1:0] req_addr_reg;
    logic [DATA_W-1:0] req_wdata_reg;
    logic              resp_hit_reg;
    logic [DATA_W-1:0] resp_data_reg;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    cache_line_t       cur_line;
    cache_line_t       wr_line;
    logic              wr_en;
    logic              lookup_hit;
    logic              ready_c;

    assign req_idx    = req_addr_reg[IDX_W-1:0];
    assign req_tag    = req_addr_reg[ADDR_W-1:IDX_W];
    assign lookup_hit = cur_line.valid && (cur_line.tag == req_tag);

    cache_line_store u_store (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (req_idx),
        .rd_line (cur_line),
        .wr_en   (wr_en),
        .wr_idx  (req_idx),
        .wr_line (wr_line)
    );

    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_we_reg    <= 1'b0;
            req_addr_reg  <= '0;
            req_wdata_reg <= '0;
        end else if (state_reg == ST_IDLE && bus.cpu_req_valid) begin
            req_we_reg    <= bus.cpu_req_we;
            req_addr_reg  <= bus.cpu_req_addr;
            req_wdata_reg <= bus.cpu_req_wdata;
        end
    end

    // Response word is the line content after this request's update.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_hit_reg  <= 1'b0;
            resp_data_reg <= '0;
        end else if (state_reg == ST_LOOKUP && lookup_hit) begin
            resp_hit_reg  <= 1'b1;
            resp_data_reg <= req_we_reg ? req_wdata_reg : cur_line.data;
        end else if (state_reg == ST_FILL_WAIT && bus.mem_resp_valid) begin
            resp_hit_reg  <= 1'b0;
            resp_data_reg <= req_we_reg ? req_wdata_reg : bus.mem_resp_rdata;
        end
    end

    always_comb begin
        state_next         = state_reg;
        wr_en              = 1'b0;
        wr_line            = '0;
        ready_c            = 1'b0;
        bus.cpu_resp_valid = 1'b0;
        bus.cpu_resp_rdata = '0;
        bus.cpu_resp_hit   = 1'b0;
        bus.mem_req_valid  = 1'b0;
        bus.mem_req_we     = 1'b0;
        bus.mem_req_addr   = '0;
        bus.mem_req_wdata  = '0;
        case (state_reg)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (bus.cpu_req_valid) state_next = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (lookup_hit) begin
                    if (req_we_reg) begin
                        wr_en   = 1'b1;
                        wr_line = '{valid: 1'b1, dirty: 1'b1, tag: req_tag, data: req_wdata_reg};
                    end
                    state_next = ST_RESPOND;
                end else if (cur_line.valid && cur_line.dirty) begin
                    state_next = ST_WB_REQ;
                end else begin
                    state_next = ST_FILL_REQ;
                end
            end
            ST_WB_REQ: begin
                // Victim line is untouched until the fill, so these fields stay stable.
                bus.mem_req_valid = 1'b1;
                bus.mem_req_we    = 1'b1;
                bus.mem_req_addr  = {cur_line.tag, req_idx};
                bus.mem_req_wdata = cur_line.data;
                if (bus.mem_req_ready) state_next = ST_FILL_REQ;
            end
            ST_FILL_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = req_addr_reg;
                if (bus.mem_req_ready) state_next = ST_FILL_WAIT;
            end
            ST_FILL_WAIT: begin
                if (bus.mem_resp_valid) begin
                    wr_en      = 1'b1;
                    wr_line    = '{valid: 1'b1, dirty: req_we_reg, tag: req_tag,
                                   data: req_we_reg ? req_wdata_reg : bus.mem_resp_rdata};
                    state_next = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                bus.cpu_resp_valid = 1'b1;
                bus.cpu_resp_rdata = resp_data_reg;
                bus.cpu_resp_hit   = resp_hit_reg;
                state_next         = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.cpu_req_ready = ready_c && !rst;
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: directed vector table, reset-abandon sequence and
// randomized traffic checked against an abstract cache + memory model.
module tb_cache_ctrl;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_ctrl_if ifc ();

    cache_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int errors = 0;
    int checks = 0;
    int txn_no = 0;

    logic [31:0] mem_model [256];
    logic [31:0] ref_mem   [256];
    bit          ref_valid [LINES];
    bit          ref_dirty [LINES];
    int          ref_tag   [LINES];
    logic [31:0] ref_data  [LINES];

    logic        mlog_we   [$];
    logic [7:0]  mlog_addr [$];
    logic [31:0] mlog_data [$];

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          stall;
        logic        exp_hit;
        logic [31:0] exp_rd;
        logic        exp_wb;
        logic [7:0]  exp_wb_addr;
        logic [31:0] exp_wb_data;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < LINES; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
        end
    endtask

    // Abstract model: line = addr mod LINES, tag = addr div LINES.
    task automatic ref_access(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                              output logic hit, output logic [31:0] rd, output logic wb,
                              output logic [7:0] wb_addr, output logic [31:0] wb_data);
        int i;
        int t;
        i       = int'(addr) % LINES;
        t       = int'(addr) / LINES;
        hit     = ref_valid[i] && ref_tag[i] == t;
        wb      = !hit && ref_valid[i] && ref_dirty[i];
        wb_addr = 8'(ref_tag[i] * LINES + i);
        wb_data = ref_data[i];
        if (wb) ref_mem[wb_addr] = wb_data;
        if (!hit) begin
            ref_valid[i] = 1'b1;
            ref_dirty[i] = 1'b0;
            ref_tag[i]   = t;
            ref_data[i]  = ref_mem[addr];
        end
        if (we) begin
            ref_data[i]  = wd;
            ref_dirty[i] = 1'b1;
        end
        rd = ref_data[i];
    endtask

    // Runs one request from a negedge in IDLE; acts as memory (ready unless stalling a fill,
    // fill data two cycles after the read handshake).
    task automatic do_req(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                          input int stall, output logic [31:0] rd, output logic hit,
                          output int lat);
        int cyc, acc, timer, stall_left;
        bit done, busy_bad, unstable, holding;
        logic [7:0] hold_addr, fill_addr;
        mlog_we.delete();
        mlog_addr.delete();
        mlog_data.delete();
        rd = '0; hit = 1'b0; lat = -1;
        acc = -1; timer = -1; stall_left = stall;
        done = 0; busy_bad = 0; unstable = 0; holding = 0;
        hold_addr = '0; fill_addr = '0;
        ifc.cpu_req_valid = 1'b1;
        ifc.cpu_req_we    = we;
        ifc.cpu_req_addr  = addr;
        ifc.cpu_req_wdata = wd;
        for (cyc = 0; cyc < 100 && !done; cyc++) begin
            if (acc >= 0) begin
                ifc.cpu_req_valid = 1'b0;
                if (ifc.cpu_req_ready) busy_bad = 1;
            end else if (ifc.cpu_req_ready) begin
                acc = cyc;
            end
            ifc.mem_resp_valid = 1'b0;
            ifc.mem_resp_rdata = '0;
            if (timer > 0) timer--;
            if (timer == 0) begin
                ifc.mem_resp_valid = 1'b1;
                ifc.mem_resp_rdata = mem_model[fill_addr];
                timer = -1;
            end
            ifc.mem_req_ready = 1'b0;
            if (ifc.mem_req_valid) begin
                if (!ifc.mem_req_we && stall_left > 0) begin
                    if (!holding) begin
                        holding   = 1;
                        hold_addr = ifc.mem_req_addr;
                    end else if (ifc.mem_req_addr !== hold_addr || ifc.mem_req_we !== 1'b0) begin
                        unstable = 1;
                    end
                    if (stall_left == 3) begin
                        ifc.mem_resp_valid = 1'b1;
                        ifc.mem_resp_rdata = 32'hBAD0_BAD0;
                    end
                    stall_left--;
                end else begin
                    if (holding && ifc.mem_req_addr !== hold_addr) unstable = 1;
                    ifc.mem_req_ready = 1'b1;
                    mlog_we.push_back(ifc.mem_req_we);
                    mlog_addr.push_back(ifc.mem_req_addr);
                    mlog_data.push_back(ifc.mem_req_wdata);
                    if (ifc.mem_req_we) begin
                        mem_model[ifc.mem_req_addr] = ifc.mem_req_wdata;
                    end else begin
                        fill_addr = ifc.mem_req_addr;
                        timer     = 2;
                    end
                end
            end
            if (ifc.cpu_resp_valid) begin
                done = 1;
                rd   = ifc.cpu_resp_rdata;
                hit  = ifc.cpu_resp_hit;
                lat  = cyc - acc;
            end
            @(negedge clk);
        end
        ifc.cpu_req_valid  = 1'b0;
        ifc.mem_req_ready  = 1'b0;
        ifc.mem_resp_valid = 1'b0;
        chk("resp_timeout", 32'(done), 32'd1);
        chk("ready_while_busy", 32'(busy_bad), 32'd0);
        chk("single_resp_pulse", 32'(ifc.cpu_resp_valid), 32'd0);
        chk("ready_after_resp", 32'(ifc.cpu_req_ready), 32'd1);
        if (stall > 0) chk("mem_req_stable", 32'(unstable), 32'd0);
    endtask

    task automatic run_check(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                             input int stall, input logic exp_hit, input logic [31:0] exp_rd,
                             input logic exp_wb, input logic [7:0] exp_wb_addr,
                             input logic [31:0] exp_wb_data);
        logic [31:0] rd;
        logic        hit;
        int          lat, n_exp, k;
        do_req(we, addr, wd, stall, rd, hit, lat);
        $display("txn %0d we=%0d addr=%02h wdata=%08h -> rdata=%08h hit=%0d lat=%0d mem_ops=%0d",
                 txn_no, we, addr, wd, rd, hit, lat, mlog_we.size());
        chk($sformatf("t%0d hit", txn_no), 32'(hit), 32'(exp_hit));
        chk($sformatf("t%0d rdata", txn_no), rd, exp_rd);
        n_exp = (exp_hit ? 0 : 1) + (exp_wb ? 1 : 0);
        chk($sformatf("t%0d mem_ops", txn_no), 32'(mlog_we.size()), 32'(n_exp));
        k = 0;
        if (exp_wb && mlog_we.size() > 0) begin
            chk($sformatf("t%0d wb_we", txn_no), 32'(mlog_we[0]), 32'd1);
            chk($sformatf("t%0d wb_addr", txn_no), 32'(mlog_addr[0]), 32'(exp_wb_addr));
            chk($sformatf("t%0d wb_data", txn_no), mlog_data[0], exp_wb_data);
            k = 1;
        end
        if (!exp_hit && mlog_we.size() > k) begin
            chk($sformatf("t%0d fill_we", txn_no), 32'(mlog_we[k]), 32'd0);
            chk($sformatf("t%0d fill_addr", txn_no), 32'(mlog_addr[k]), 32'(addr));
        end
        if (exp_hit) chk($sformatf("t%0d hit_latency", txn_no), 32'(lat), 32'd2);
        txn_no++;
    endtask

    initial begin
        logic        m_hit, m_wb;
        logic [31:0] m_rd, m_wb_data;
        logic [7:0]  m_wb_addr;
        logic        r_we;
        logic [7:0]  r_addr;
        logic [31:0] r_wd;

        rst = 1'b1;
        ifc.cpu_req_valid  = 1'b0;
        ifc.cpu_req_we     = 1'b0;
        ifc.cpu_req_addr   = '0;
        ifc.cpu_req_wdata  = '0;
        ifc.mem_req_ready  = 1'b0;
        ifc.mem_resp_valid = 1'b0;
        ifc.mem_resp_rdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem_model[i] = 32'hC0DE_0000 | 32'(i);
            ref_mem[i]   = mem_model[i];
        end
        mem_model[8'h05] = 32'hDEAD_BEEF;
        ref_mem[8'h05]   = 32'hDEAD_BEEF;
        ref_reset();

        vecs[0] = '{1'b0, 8'h05, 32'h0,         0, 1'b0, 32'hDEAD_BEEF, 1'b0, 8'h00, 32'h0};
        vecs[1] = '{1'b0, 8'h05, 32'h0,         0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00, 32'h0};
        vecs[2] = '{1'b1, 8'h09, 32'h1234_5678, 0, 1'b0, 32'h1234_5678, 1'b0, 8'h00, 32'h0};
        vecs[3] = '{1'b0, 8'h0D, 32'h0,         0, 1'b0, 32'hC0DE_000D, 1'b1, 8'h09, 32'h1234_5678};
        vecs[4] = '{1'b1, 8'h0D, 32'hA5A5_A5A5, 0, 1'b1, 32'hA5A5_A5A5, 1'b0, 8'h00, 32'h0};
        vecs[5] = '{1'b0, 8'h01, 32'h0,         0, 1'b0, 32'hC0DE_0001, 1'b1, 8'h0D, 32'hA5A5_A5A5};
        vecs[6] = '{1'b0, 8'h15, 32'h0,         5, 1'b0, 32'hC0DE_0015, 1'b0, 8'h00, 32'h0};
        vecs[7] = '{1'b0, 8'h09, 32'h0,         0, 1'b0, 32'h1234_5678, 1'b0, 8'h00, 32'h0};

        // Reset state: everything low while rst is held, ready once released.
        repeat (3) @(negedge clk);
        chk("rst cpu_req_ready", 32'(ifc.cpu_req_ready), 32'd0);
        chk("rst cpu_resp_valid", 32'(ifc.cpu_resp_valid), 32'd0);
        chk("rst mem_req_valid", 32'(ifc.mem_req_valid), 32'd0);
        chk("rst cpu_resp_rdata", ifc.cpu_resp_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst cpu_req_ready", 32'(ifc.cpu_req_ready), 32'd1);

        for (int v = 0; v < 8; v++) begin
            ref_access(vecs[v].we, vecs[v].addr, vecs[v].wdata,
                       m_hit, m_rd, m_wb, m_wb_addr, m_wb_data);
            run_check(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].stall,
                      vecs[v].exp_hit, vecs[v].exp_rd, vecs[v].exp_wb,
                      vecs[v].exp_wb_addr, vecs[v].exp_wb_data);
        end

        // Reset during FILL_WAIT abandons the load and leaves every line invalid.
        ifc.cpu_req_valid = 1'b1;
        ifc.cpu_req_we    = 1'b0;
        ifc.cpu_req_addr  = 8'h06;
        @(negedge clk);
        ifc.cpu_req_valid = 1'b0;
        @(negedge clk);
        chk("abort fill_req_valid", 32'(ifc.mem_req_valid), 32'd1);
        chk("abort fill_req_addr", 32'(ifc.mem_req_addr), 32'h06);
        ifc.mem_req_ready = 1'b1;
        @(negedge clk);
        ifc.mem_req_ready = 1'b0;
        chk("abort in_fill_wait", 32'(ifc.mem_req_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort rst cpu_resp_valid", 32'(ifc.cpu_resp_valid), 32'd0);
        chk("abort rst mem_req_valid", 32'(ifc.mem_req_valid), 32'd0);
        chk("abort rst cpu_req_ready", 32'(ifc.cpu_req_ready), 32'd0);
        chk("abort rst cpu_resp_rdata", ifc.cpu_resp_rdata, 32'd0);
        rst = 1'b0;
        ifc.mem_resp_valid = 1'b1;
        ifc.mem_resp_rdata = 32'hFEED_FACE;
        @(negedge clk);
        ifc.mem_resp_valid = 1'b0;
        chk("abort idle cpu_req_ready", 32'(ifc.cpu_req_ready), 32'd1);
        chk("abort idle cpu_resp_valid", 32'(ifc.cpu_resp_valid), 32'd0);
        ref_reset();
        ref_access(1'b0, 8'h05, 32'h0, m_hit, m_rd, m_wb, m_wb_addr, m_wb_data);
        run_check(1'b0, 8'h05, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 8'h00, 32'h0);

        // Randomized traffic over a small address window to force conflicts and writebacks.
        for (int n = 0; n < 150; n++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_addr = 8'($urandom_range(0, 23));
            r_wd   = $urandom;
            ref_access(r_we, r_addr, r_wd, m_hit, m_rd, m_wb, m_wb_addr, m_wb_data);
            run_check(r_we, r_addr, r_wd, int'($urandom_range(0, 2)),
                      m_hit, m_rd, m_wb, m_wb_addr, m_wb_data);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
